axi_simple_master: RTL and testbench

- Single-outstanding AXI4 initiator that turns a simple valid/ready command/response interface into single-beat AXI4 read and write transactions.
- Drives the AXI slave port of the on-chip RAM, using the same `ariane_axi_pkg::m_req_t` / `m_resp_t` structs that the core master uses.
- Used by bench/FPGA bring-up logic to preload program images, poke memory and read memory back without the core.

---
 rtl/ariane_axi_pkg.sv | 88 ++++++++
 rtl/axi_simple_master_pkg.sv | 36 +++
 rtl/axi_simple_master.sv | 186 ++++++++++++++++++
 tb/tb_axi_simple_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_axi_pkg.sv
// Local copy of the AXI4 request/response channel structs used by the core master port.
// Only the types needed by bring-up initiators are reproduced here.
package ariane_axi_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [UserWidth-1:0] user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } m_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } m_resp_t;

endpackage

// File: rtl/axi_simple_master_pkg.sv
// Shared constants and FSM encoding for the single-outstanding AXI4 bring-up initiator.
package axi_simple_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_e;

  localparam int unsigned DataW   = 64;
  localparam int unsigned AxiSize = $clog2(DataW / 8);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam logic [1:0] BurstIncr = 2'b01;

  // Anything other than OKAY is reported as an error, EXOKAY included.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      RespOkay:   err = 1'b0;
      RespExokay: err = 1'b1;
      RespSlverr: err = 1'b1;
      RespDecerr: err = 1'b1;
      default:    err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axi_simple_master.sv
// Single-outstanding AXI4 initiator: one valid/ready command becomes one single-beat
// AXI read or write, answered by one valid/ready response.
module axi_simple_master
  import axi_simple_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned AXI_ID = 0,
  parameter type         req_t  = ariane_axi_pkg::m_req_t,
  parameter type         resp_t = ariane_axi_pkg::m_resp_t
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output req_t                req_o,
  input  resp_t               resp_i
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);
  localparam int unsigned IdW  = $bits(req_o.aw.id);
  localparam logic [ADDR_W-1:0] AddrMask = ~ADDR_W'((64'd1 << OffW) - 64'd1);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic unused_resp;

  assign aw_hs = req_q.aw_valid & resp_i.aw_ready;
  assign w_hs  = req_q.w_valid & resp_i.w_ready;
  assign ar_hs = req_q.ar_valid & resp_i.ar_ready;
  assign b_hs  = resp_i.b_valid & req_q.b_ready;
  assign r_hs  = resp_i.r_valid & req_q.r_ready;

  // IDs, user bits and rlast carry no information for a single-beat, single-ID master.
  assign unused_resp = ^{resp_i.b.id, resp_i.b.user, resp_i.r.id, resp_i.r.last, resp_i.r.user};

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (cmd_we_i) begin
            req_d.aw       = '0;
            req_d.aw.id    = IdW'(AXI_ID);
            req_d.aw.addr  = cmd_addr_i & AddrMask;
            req_d.aw.size  = 3'(AxiSize);
            req_d.aw.burst = BurstIncr;
            req_d.w        = '0;
            req_d.w.data   = cmd_wdata_i;
            req_d.w.strb   = cmd_strb_i;
            req_d.w.last   = 1'b1;
            req_d.aw_valid = 1'b1;
            req_d.w_valid  = 1'b1;
            state_d        = WRITE;
          end else begin
            req_d.ar       = '0;
            req_d.ar.id    = IdW'(AXI_ID);
            req_d.ar.addr  = cmd_addr_i & AddrMask;
            req_d.ar.size  = 3'(AxiSize);
            req_d.ar.burst = BurstIncr;
            req_d.ar_valid = 1'b1;
            state_d        = RADDR;
          end
        end
      end

      // AW and W complete independently; each valid drops right after its own handshake.
      WRITE: begin
        if (aw_hs) begin
          req_d.aw_valid = 1'b0;
          aw_done_d      = 1'b1;
        end
        if (w_hs) begin
          req_d.w_valid = 1'b0;
          w_done_d      = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          req_d.b_ready = 1'b1;
          state_d       = WRESP;
        end
      end

      WRESP: begin
        if (b_hs) begin
          req_d.b_ready = 1'b0;
          rsp_err_d     = resp_is_err(resp_i.b.resp);
          rsp_rdata_d   = '0;
          rsp_valid_d   = 1'b1;
          state_d       = RSP;
        end
      end

      RADDR: begin
        if (ar_hs) begin
          req_d.ar_valid = 1'b0;
          req_d.r_ready  = 1'b1;
          state_d        = RDATA;
        end
      end

      RDATA: begin
        if (r_hs) begin
          req_d.r_ready = 1'b0;
          rsp_err_d     = resp_is_err(resp_i.r.resp);
          rsp_rdata_d   = resp_i.r.data;
          rsp_valid_d   = 1'b1;
          state_d       = RSP;
        end
      end

      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        req_d       = '0;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  assign req_o       = req_q;
  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_axi_simple_master.sv
// Bench for axi_simple_master: small AXI RAM slave with programmable ready/response
// delays, a response scoreboard and a cycle-stamping handshake monitor.
module tb_axi_simple_master;
  import ariane_axi_pkg::*;

  localparam logic [63:0] DecData = 64'hDEC0_DEC0_DEC0_DEC0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [63:0] cmd_addr_i = '0;
  logic [63:0] cmd_wdata_i = '0;
  logic [7:0]  cmd_strb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  m_req_t      dut_req;
  m_resp_t     slv_resp;

  always #5 clk = ~clk;

  axi_simple_master dut (
    .clk_i      (clk),
    .arst_ni    (rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .cmd_strb_i (cmd_strb_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .req_o      (dut_req),
    .resp_i     (slv_resp)
  );

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  int          aw_cnt, w_cnt, b_cnt;
  logic        have_aw, have_w, b_pend;
  logic [63:0] st_addr, st_data;
  logic [7:0]  st_strb;
  logic        b_valid, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [63:0] r_data;
  logic [63:0] mem [0:255];
  logic        slv_aw_hs, slv_w_hs, slv_ar_hs;
  logic [63:0] wr_addr_c, wr_data_c;
  logic [7:0]  wr_strb_c;

  function automatic logic mapped(input logic [63:0] a);
    return (a >= 64'h8000_0000) && (a < 64'h8000_0800);
  endfunction

  always_comb begin
    slv_resp          = '0;
    slv_resp.aw_ready = dut_req.aw_valid && (aw_cnt >= aw_dly);
    slv_resp.w_ready  = dut_req.w_valid && (w_cnt >= w_dly);
    slv_resp.ar_ready = dut_req.ar_valid;
    slv_resp.b_valid  = b_valid;
    slv_resp.b.resp   = b_resp;
    slv_resp.r_valid  = r_valid;
    slv_resp.r.data   = r_data;
    slv_resp.r.resp   = r_resp;
    slv_resp.r.last   = 1'b1;
  end

  assign slv_aw_hs = dut_req.aw_valid && slv_resp.aw_ready;
  assign slv_w_hs  = dut_req.w_valid && slv_resp.w_ready;
  assign slv_ar_hs = dut_req.ar_valid && slv_resp.ar_ready;
  assign wr_addr_c = slv_aw_hs ? dut_req.aw.addr : st_addr;
  assign wr_data_c = slv_w_hs ? dut_req.w.data : st_data;
  assign wr_strb_c = slv_w_hs ? dut_req.w.strb : st_strb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; b_pend <= 1'b0;
      st_addr <= '0; st_data <= '0; st_strb <= '0;
      b_valid <= 1'b0; b_resp <= 2'b00;
      r_valid <= 1'b0; r_resp <= 2'b00; r_data <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (slv_aw_hs) aw_cnt <= 0; else if (dut_req.aw_valid) aw_cnt <= aw_cnt + 1;
      if (slv_w_hs) w_cnt <= 0; else if (dut_req.w_valid) w_cnt <= w_cnt + 1;
      if (slv_aw_hs) begin have_aw <= 1'b1; st_addr <= dut_req.aw.addr; end
      if (slv_w_hs) begin have_w <= 1'b1; st_data <= dut_req.w.data; st_strb <= dut_req.w.strb; end
      if ((have_aw || slv_aw_hs) && (have_w || slv_w_hs)) begin
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        if (mapped(wr_addr_c)) begin
          for (int j = 0; j < 8; j++)
            if (wr_strb_c[j]) mem[wr_addr_c[10:3]][8*j +: 8] <= wr_data_c[8*j +: 8];
        end
        b_resp <= mapped(wr_addr_c) ? 2'b00 : 2'b11;
        if (b_dly == 0) b_valid <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= b_dly - 1; end
      end
      if (b_pend) begin
        if (b_cnt == 0) begin b_valid <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt - 1;
      end
      if (b_valid && dut_req.b_ready) b_valid <= 1'b0;
      if (slv_ar_hs) begin
        r_valid <= 1'b1;
        r_data  <= mapped(dut_req.ar.addr) ? mem[dut_req.ar.addr[10:3]] : DecData;
        r_resp  <= mapped(dut_req.ar.addr) ? 2'b00 : 2'b11;
      end
      if (r_valid && dut_req.r_ready) r_valid <= 1'b0;
    end
  end

  // ---------------- handshake monitor ----------------
  int          cyc = 0, acc_cnt = 0, n_rsp = 0;
  int          acc_cyc, aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc, rsp_cyc;
  int          aw_vtot = 0, w_vtot = 0, withdraw_viol = 0, rsp_axi_viol = 0;
  logic        aw_pend, w_pend, ar_pend, rsp_prev;
  logic [63:0] aw_addr_seen;
  logic [7:0]  aw_len_seen, w_strb_seen;
  logic [2:0]  aw_size_seen;
  logic [1:0]  aw_burst_seen;
  logic        w_last_seen;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0; rsp_prev = 1'b0;
    end else begin
      if (cmd_valid_i && cmd_ready_o) begin acc_cyc = cyc; acc_cnt++; end
      if (aw_pend && !dut_req.aw_valid) withdraw_viol++;
      if (w_pend && !dut_req.w_valid) withdraw_viol++;
      if (ar_pend && !dut_req.ar_valid) withdraw_viol++;
      aw_pend = dut_req.aw_valid && !slv_resp.aw_ready;
      w_pend  = dut_req.w_valid && !slv_resp.w_ready;
      ar_pend = dut_req.ar_valid && !slv_resp.ar_ready;
      if (dut_req.aw_valid) aw_vtot++;
      if (dut_req.w_valid) w_vtot++;
      if (slv_aw_hs) begin
        aw_cyc = cyc; aw_addr_seen = dut_req.aw.addr; aw_len_seen = dut_req.aw.len;
        aw_size_seen = dut_req.aw.size; aw_burst_seen = dut_req.aw.burst;
      end
      if (slv_w_hs) begin w_cyc = cyc; w_strb_seen = dut_req.w.strb; w_last_seen = dut_req.w.last; end
      if (b_valid && dut_req.b_ready) b_cyc = cyc;
      if (slv_ar_hs) ar_cyc = cyc;
      if (r_valid && dut_req.r_ready) r_cyc = cyc;
      if (rsp_valid_o && !rsp_prev) rsp_cyc = cyc;
      rsp_prev = rsp_valid_o;
      if (rsp_valid_o && rsp_ready_i) n_rsp++;
      if (rsp_valid_o && (dut_req.aw_valid || dut_req.w_valid || dut_req.ar_valid)) rsp_axi_viol++;
    end
    cyc++;
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_errors = 0, n_done = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command, then compare the response against the scoreboard head.
  task automatic do_cmd(input string tag, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] strb,
                        input logic [63:0] exp_data, input logic exp_err, input int hold);
    int   snap;
    logic got;
    exp_t e;
    sb_q.push_back({exp_data, exp_err});
    cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_strb_i = strb;
    cmd_valid_i = 1'b1;
    snap = acc_cnt;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != snap) begin got = 1'b1; break; end
    end
    cmd_valid_i = 1'b0;
    if (!got) begin
      check({tag, "_accept_timeout"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin got = 1'b1; break; end
    end
    e = sb_q.pop_front();
    if (!got) begin
      check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 64'(rsp_valid_o), 64'd1);
      check({tag, "_hold_data"}, rsp_rdata_o, e.data);
      check({tag, "_hold_cmd_ready"}, 64'(cmd_ready_o), 64'd0);
      @(negedge clk);
    end
    check({tag, "_data"}, rsp_rdata_o, e.data);
    check({tag, "_err"}, 64'(rsp_err_o), 64'(e.err));
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    n_done++;
    check({tag, "_rsp_drop"}, 64'(rsp_valid_o), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata_o, 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
    check({tag, "_req_zero"}, 64'(dut_req == '0), 64'd1);
  endtask

  initial begin
    int a0, w0, r0;
    logic got;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("cmd_ready_before_edge", 64'(cmd_ready_o), 64'd0);
    @(negedge clk);
    check("cmd_ready_after_reset", 64'(cmd_ready_o), 64'd1);

    // Zero-wait write and readback with latency and field checks.
    do_cmd("wr0", 1'b1, 64'h8000_0000, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'd0, 1'b0, 0);
    check("wr0_aw_lat", 64'(aw_cyc - acc_cyc), 64'd1);
    check("wr0_w_lat", 64'(w_cyc - acc_cyc), 64'd1);
    check("wr0_b_lat", 64'(b_cyc - acc_cyc), 64'd2);
    check("wr0_rsp_lat", 64'(rsp_cyc - acc_cyc), 64'd3);
    check("wr0_awaddr", aw_addr_seen, 64'h8000_0000);
    check("wr0_awsize", 64'(aw_size_seen), 64'd3);
    check("wr0_awlen", 64'(aw_len_seen), 64'd0);
    check("wr0_awburst", 64'(aw_burst_seen), 64'd1);
    check("wr0_wlast", 64'(w_last_seen), 64'd1);
    check("wr0_wstrb", 64'(w_strb_seen), 64'hFF);
    do_cmd("rd0", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b0, 0);
    check("rd0_ar_lat", 64'(ar_cyc - acc_cyc), 64'd1);
    check("rd0_r_lat", 64'(r_cyc - acc_cyc), 64'd2);
    check("rd0_rsp_lat", 64'(rsp_cyc - acc_cyc), 64'd3);

    // Partial strobes, unaligned address, zero strobe.
    do_cmd("wr_lo", 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_AAAA_5555, 8'h0F, 64'd0, 1'b0, 0);
    do_cmd("rd_lo", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h0000_0000_AAAA_5555, 1'b0, 0);
    do_cmd("wr_unal", 1'b1, 64'h8000_000C, 64'h1111_2222_3333_4444, 8'hF0, 64'd0, 1'b0, 0);
    check("wr_unal_awaddr", aw_addr_seen, 64'h8000_0008);
    do_cmd("rd_unal", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1111_2222_AAAA_5555, 1'b0, 0);
    do_cmd("wr_strb0", 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0, 0);
    check("wr_strb0_wstrb", 64'(w_strb_seen), 64'd0);
    do_cmd("rd_strb0", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1111_2222_AAAA_5555, 1'b0, 0);

    // Address before data and data before address.
    aw_dly = 3; w_dly = 0;
    a0 = aw_vtot; w0 = w_vtot; r0 = n_rsp;
    do_cmd("wr_awslow", 1'b1, 64'h8000_0010, 64'h0102_0304_0506_0708, 8'hFF, 64'd0, 1'b0, 0);
    check("wr_awslow_aw_cycles", 64'(aw_vtot - a0), 64'd4);
    check("wr_awslow_w_cycles", 64'(w_vtot - w0), 64'd1);
    check("wr_awslow_rsp_count", 64'(n_rsp - r0), 64'd1);
    aw_dly = 0; w_dly = 3;
    a0 = aw_vtot; w0 = w_vtot; r0 = n_rsp;
    do_cmd("wr_wslow", 1'b1, 64'h8000_0018, 64'h1020_3040_5060_7080, 8'hFF, 64'd0, 1'b0, 0);
    check("wr_wslow_aw_cycles", 64'(aw_vtot - a0), 64'd1);
    check("wr_wslow_w_cycles", 64'(w_vtot - w0), 64'd4);
    check("wr_wslow_rsp_count", 64'(n_rsp - r0), 64'd1);
    w_dly = 0;
    do_cmd("rd_awslow", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h0102_0304_0506_0708, 1'b0, 0);
    do_cmd("rd_wslow", 1'b0, 64'h8000_0018, 64'd0, 8'h00, 64'h1020_3040_5060_7080, 1'b0, 0);

    // Decode error, then recovery.
    do_cmd("rd_decerr", 1'b0, 64'h1000_0000, 64'd0, 8'h00, DecData, 1'b1, 0);
    do_cmd("rd_after_err", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b0, 0);

    // Response back-pressure.
    do_cmd("rd_hold", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1111_2222_AAAA_5555, 1'b0, 5);

    // Asynchronous reset while waiting for B.
    b_dly = 20;
    cmd_we_i = 1'b1; cmd_addr_i = 64'h8000_0020; cmd_wdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
    cmd_strb_i = 8'hFF; cmd_valid_i = 1'b1;
    @(posedge clk); #1 cmd_valid_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut_req.b_ready) begin got = 1'b1; break; end
    end
    check("wresp_reached", 64'(got), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    b_dly = 0;
    rst_n = 1'b1;
    #1 check("post_reset_cmd_ready_low", 64'(cmd_ready_o), 64'd0);
    @(negedge clk);
    check("post_reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    do_cmd("wr_post_reset", 1'b1, 64'h8000_0020, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'd0, 1'b0, 0);
    check("wr_post_reset_rsp_lat", 64'(rsp_cyc - acc_cyc), 64'd3);
    do_cmd("rd_post_reset", 1'b0, 64'h8000_0020, 64'd0, 8'h00, 64'hCAFE_F00D_1234_5678, 1'b0, 0);

    // Global protocol observations.
    repeat (3) @(negedge clk);
    check("valid_withdrawn", 64'(withdraw_viol), 64'd0);
    check("axi_valid_in_rsp", 64'(rsp_axi_viol), 64'd0);
    check("rsp_count", 64'(n_rsp), 64'(n_done));
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
